uart_stim_tx: RTL and testbench

UART_STIM_TX -- requirements
Module: uart_stim_tx

---
 rtl/uart_stim_pkg.sv | 21 ++
 rtl/uart_stim_fifo.sv | 64 ++++++
 rtl/uart_stim_tx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_stim_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stim_pkg.sv
// Shared FSM encoding and bit-timing constants for the UART stimulus transmitter.
// UART_STIM_TX_PARITY_EN adds the PARITY state and the parity helper.
package uart_stim_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned TICK_CNT_W    = $clog2(TICKS_PER_BIT);
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned BIT_CNT_W     = 3;

`ifdef UART_STIM_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

endpackage

// File: rtl/uart_stim_fifo.sv
// Byte FIFO feeding the transmitter: show-ahead head, one-cycle pop, registered level/ready.
module uart_stim_fifo
  import uart_stim_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       core_clk,
  input  logic                       rst_l,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head_c,
  output logic                       o_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ready;
  logic              w_push;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level_nxt;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && (r_level != '0);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge core_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_ready  = r_ready;
  assign o_level  = r_level;

endmodule

// File: rtl/uart_stim_tx.sv
// UART transmit stimulus generator: FIFO-fed 8-bit frames timed by a 16x baud tick.
// Define UART_STIM_TX_PARITY_EN to enable the optional parity bit; otherwise frames are 8N.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                            core_clk,
  input  logic                            rst_l,
  input  logic                            tx_enable,
  input  logic                            tick_baud_x16,
  input  logic                            parity_enable,
  input  logic                            parity_odd,
  input  logic                            wr_valid,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            wr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            tx,
  output logic                            busy,
  output logic                            frame_done
);

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic [TICK_CNT_W-1:0] r_tick_cnt;
  logic [TICK_CNT_W-1:0] w_tick_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_nxt;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shift_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  w_done_nxt;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_can_start;
  logic                  w_bit_end;
  logic [DATA_W-1:0]     w_head;

`ifdef UART_STIM_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;
  logic w_par_en_nxt;
  logic w_par_bit_nxt;
`else
  logic w_unused_parity;
  assign w_unused_parity = parity_enable ^ parity_odd;
`endif

  uart_stim_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk    (core_clk),
    .rst_l       (rst_l),
    .i_push      (wr_valid),
    .i_push_data (wr_data),
    .i_pop       (w_pop),
    .o_head_c    (w_head),
    .o_ready     (wr_ready),
    .o_level     (fifo_level)
  );

  assign w_can_start = tx_enable && (fifo_level != '0);
  assign w_bit_end   = tick_baud_x16 && (r_tick_cnt == TICK_CNT_W'(TICKS_PER_BIT - 1));

  // Next-state and next-output logic; tx is computed one cycle ahead so it can be registered.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
`ifdef UART_STIM_TX_PARITY_EN
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
`endif

    if (tick_baud_x16 && (r_state != IDLE)) begin
      w_tick_nxt = w_bit_end ? '0 : r_tick_cnt + TICK_CNT_W'(1);
    end

    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_can_start) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
            w_bit_nxt = '0;
`ifdef UART_STIM_TX_PARITY_EN
            if (r_par_en) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit_cnt + BIT_CNT_W'(1);
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
`ifdef UART_STIM_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
            w_done_nxt = 1'b1;
            if (w_can_start) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_bit_nxt   = '0;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Frame start: pop the head byte and latch the per-frame parity settings.
    if (w_load) begin
      w_state_nxt = START;
      w_pop       = 1'b1;
      w_shift_nxt = w_head;
      w_tick_nxt  = '0;
      w_bit_nxt   = '0;
      w_tx_nxt    = 1'b0;
`ifdef UART_STIM_TX_PARITY_EN
      w_par_en_nxt  = parity_enable;
      w_par_bit_nxt = parity_bit(w_head, parity_odd);
`endif
    end
  end

  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef UART_STIM_TX_PARITY_EN
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= w_done_nxt;
`ifdef UART_STIM_TX_PARITY_EN
      r_par_en     <= w_par_en_nxt;
      r_par_bit    <= w_par_bit_nxt;
`endif
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Scoreboard bench for uart_stim_tx: directed pushes queue expected frames, a line receiver checks them.
module tb_uart_stim_tx;

  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned STOP_BITS   = 1;
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH + 1);
  localparam int          TICK_PERIOD = 3;

  logic             core_clk;
  logic             rst_l;
  logic             tx_enable;
  logic             tick_baud_x16;
  logic             parity_enable;
  logic             parity_odd;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             tx;
  logic             busy;
  logic             frame_done;

  typedef struct packed {
    logic [7:0] data;
    logic       has_par;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   fd_count    = 0;
  int   n;
  int   fd_before;

  logic        rx_busy, have_prev, prev_tx, prev_fd, rx_sb_ok;
  int          rx_cnt, rx_k, rx_nbits, rx_next, prev_nbits, last_gap;
  logic [11:0] rx_bits;
  exp_t        rx_exp;

  uart_stim_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .core_clk      (core_clk),
    .rst_l         (rst_l),
    .tx_enable     (tx_enable),
    .tick_baud_x16 (tick_baud_x16),
    .parity_enable (parity_enable),
    .parity_odd    (parity_odd),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .fifo_level    (fifo_level),
    .tx            (tx),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  initial begin
    tick_baud_x16 = 1'b0;
    forever begin
      for (int i = 0; i < TICK_PERIOD; i++) begin
        @(posedge core_clk);
        #1 tick_baud_x16 = (i == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] frame_bits(input exp_t e);
    logic [11:0] b;
    int          idx;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = e.data[i];
    idx = 9;
    if (e.has_par) begin
      b[9] = e.par;
      idx  = 10;
    end
    for (int i = 0; i < STOP_BITS; i++) b[idx+i] = 1'b1;
    return b;
  endfunction

  // Line receiver: counts consumed ticks from each start edge, samples mid-bit, checks edges and frame_done.
  always @(negedge core_clk) begin
    if (!rst_l) begin
      rx_busy   = 1'b0;
      have_prev = 1'b0;
      prev_tx   = 1'b1;
      prev_fd   = 1'b0;
      rx_cnt    = 0;
    end else begin
      if (frame_done) begin
        fd_count++;
        check("fd_single_cycle", int'(prev_fd), 0);
        check("fd_after_frame", int'(have_prev && !rx_busy), 1);
        if (have_prev) check("fd_tick_position", rx_cnt, 16 * prev_nbits);
      end
      if (rx_busy && (tx != prev_tx)) check("bit_width", rx_cnt % 16, 0);
      if (!rx_busy && !tx && prev_tx) begin
        last_gap = have_prev ? rx_cnt - 16 * prev_nbits : -1;
        rx_busy  = 1'b1;
        rx_cnt   = 0;
        rx_k     = 0;
        rx_next  = 8;
        rx_bits  = '0;
        check("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          rx_exp   = exp_q.pop_front();
          rx_sb_ok = 1'b1;
        end else begin
          rx_exp   = '0;
          rx_sb_ok = 1'b0;
        end
        rx_nbits = 9 + int'(rx_exp.has_par) + STOP_BITS;
      end else if (rx_busy && (rx_cnt == rx_next)) begin
        rx_bits[rx_k] = tx;
        rx_k++;
        rx_next += 16;
        if (rx_k == rx_nbits) begin
          rx_busy    = 1'b0;
          have_prev  = 1'b1;
          prev_nbits = rx_nbits;
          if (rx_sb_ok) check("frame", int'(rx_bits), int'(frame_bits(rx_exp)));
        end
      end
      prev_fd = frame_done;
      prev_tx = tx;
      if (tick_baud_x16) rx_cnt++;
    end
  end

  task automatic step();
    @(posedge core_clk);
    #2;
  endtask

  task automatic steps(input int cnt);
    repeat (cnt) step();
  endtask

  task automatic push(input logic [7:0] d, input logic expect_tx, input logic has_par,
                      input logic par);
    exp_t e;
    e.data    = d;
    e.has_par = has_par;
    e.par     = par;
    if (expect_tx) exp_q.push_back(e);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int k;
    k = 0;
    while ((fd_count < target) && (k < budget)) begin
      step();
      k++;
    end
    check("frame_done_count", fd_count, target);
  endtask

  initial begin
    rst_l         = 1'b0;
    tx_enable     = 1'b0;
    parity_enable = 1'b0;
    parity_odd    = 1'b0;
    wr_valid      = 1'b0;
    wr_data       = '0;
    steps(3);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    rst_l = 1'b1;
    steps(2);

    // Plain 8N frame of 0x55: alternating line levels.
    tx_enable = 1'b1;
    push(8'h55, 1'b1, 1'b0, 1'b0);
    wait_fd(1, 700);
    step();
    check("t1_busy_after", int'(busy), 0);
    check("t1_tx_idle", int'(tx), 1);
    check("t1_level", int'(fifo_level), 0);
    steps(50);
    check("t1_fd_once", fd_count, 1);

    // Parity: 0x07 has three ones, so even parity = 1 and odd parity = 0.
`ifdef UART_STIM_TX_PARITY_EN
    parity_enable = 1'b1;
    parity_odd    = 1'b0;
    push(8'h07, 1'b1, 1'b1, 1'b1);
    steps(40);
    parity_odd = 1'b1;
    wait_fd(2, 800);
    push(8'h07, 1'b1, 1'b1, 1'b0);
    wait_fd(3, 800);
`else
    parity_enable = 1'b1;
    parity_odd    = 1'b1;
    push(8'h07, 1'b1, 1'b0, 1'b0);
    wait_fd(2, 800);
    parity_odd = 1'b0;
    push(8'h07, 1'b1, 1'b0, 1'b0);
    wait_fd(3, 800);
`endif
    parity_enable = 1'b0;
    parity_odd    = 1'b0;
    steps(5);

    // Fill the FIFO while disabled; the 17th byte must be dropped.
    tx_enable = 1'b0;
    steps(2);
    for (int i = 0; i < 17; i++) begin
      push(8'(8'h10 + i), (i < 16), 1'b0, 1'b0);
      if (i == 0) check("t3_level_first", int'(fifo_level), 1);
      if (i == 15) begin
        check("t3_ready_full", int'(wr_ready), 0);
        check("t3_level_full", int'(fifo_level), 16);
      end
    end
    check("t3_level_after17", int'(fifo_level), 16);
    check("t3_ready_after17", int'(wr_ready), 0);
    steps(10);
    check("t3_idle_busy", int'(busy), 0);
    check("t3_idle_tx", int'(tx), 1);
    tx_enable = 1'b1;
    wait_fd(19, 16 * 600);
    step();
    check("t3_drained_level", int'(fifo_level), 0);
    check("t3_drained_ready", int'(wr_ready), 1);

    // Back-to-back: second push coincides with the first pop, so the level holds at 1.
    push(8'hA5, 1'b1, 1'b0, 1'b0);
    push(8'h3C, 1'b1, 1'b0, 1'b0);
    check("t4_level_push_pop", int'(fifo_level), 1);
    wait_fd(21, 1500);
    check("t4_gap_ticks", last_gap, 0);
    steps(10);

    // Reset during data bit 3 of 0x96 (bit 3 = 0) with another byte queued.
    push(8'h96, 1'b1, 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(rx_busy && (rx_cnt >= 16 * 4 + 6)) && (n < 2000)) begin
      step();
      n++;
    end
    check("t5_reached_bit3", int'(rx_busy && (rx_cnt >= 16 * 4 + 6)), 1);
    check("t5_tx_pre", int'(tx), 0);
    check("t5_level_pre", int'(fifo_level), 1);
    fd_before = fd_count;
    rst_l = 1'b0;
    #1;
    check("t5_tx_async", int'(tx), 1);
    check("t5_level_async", int'(fifo_level), 0);
    check("t5_busy_async", int'(busy), 0);
    check("t5_ready_async", int'(wr_ready), 1);
    steps(3);
    rst_l = 1'b1;
    steps(600);
    check("t5_no_fd", fd_count, fd_before);
    check("t5_tx_idle", int'(tx), 1);
    check("t5_busy_idle", int'(busy), 0);

    // Drop tx_enable during START of a 3-byte burst: only the first frame is sent.
    tx_enable = 1'b0;
    push(8'h81, 1'b1, 1'b0, 1'b0);
    push(8'h42, 1'b0, 1'b0, 1'b0);
    push(8'h24, 1'b0, 1'b0, 1'b0);
    check("t6_level_loaded", int'(fifo_level), 3);
    tx_enable = 1'b1;
    n = 0;
    while (!busy && (n < 20)) begin
      step();
      n++;
    end
    check("t6_started", int'(busy), 1);
    check("t6_start_bit", int'(tx), 0);
    tx_enable = 1'b0;
    wait_fd(fd_before + 1, 800);
    steps(1200);
    check("t6_one_frame", fd_count, fd_before + 1);
    check("t6_level_left", int'(fifo_level), 2);
    check("t6_busy", int'(busy), 0);
    check("t6_tx", int'(tx), 1);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
